core_loader: RTL and testbench

Boot-time program loader and run monitor sitting directly upstream of the 16-bit pipelined core. Holds the core in reset, receives a program over a byte-serial valid/ready link, and writes it word by word into the core's instruction memory. Releases the core once the last word is written, then monitors the core's `overflow` output for the duration of the run.

---
 rtl/core_loader_pkg.sv | 25 ++
 rtl/core_loader_sat_counter.sv | 23 ++
 rtl/core_loader.sv | 147 ++++++++++++++
 tb/tb_core_loader.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_loader_pkg.sv
// Shared types and widths for the boot-time program loader.
package core_loader_pkg;

    localparam int BYTE_W     = 8;
    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 2;
    localparam int HDR_W      = HDR_BYTES * BYTE_W;
    localparam int WORD_W     = WORD_BYTES * BYTE_W;

    // Counter widths; each counter saturates at its all-ones value.
    localparam int OVF_CNT_W  = 8;
    localparam int RUN_CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_HI,
        ST_HDR_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_FLUSH,
        ST_RUN,
        ST_ERR
    } state_e;

endpackage

// File: rtl/core_loader_sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments with an async active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/core_loader.sv
// Loads a byte-serial program into instruction memory while holding the core
// in reset, then releases the core and monitors its overflow flag.
module core_loader
    import core_loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_req,
    input  logic [BYTE_W-1:0]    rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 imem_we,
    output logic [ADDR_W-1:0]    imem_addr,
    output logic [WORD_W-1:0]    imem_wdata,
    output logic                 core_reset,
    input  logic                 overflow,
    output logic                 loaded,
    output logic                 err,
    output logic                 ovf_sticky,
    output logic [OVF_CNT_W-1:0] ovf_count,
    output logic [RUN_CNT_W-1:0] run_cycles
);

    localparam logic [HDR_W-1:0] MAX_WORDS = HDR_W'(IMEM_DEPTH);

    state_e              state, state_next;
    logic                load_start;
    logic                rx_fire;
    logic [BYTE_W-1:0]   hdr_hi;
    logic [BYTE_W-1:0]   data_hi;
    logic [HDR_W-1:0]    hdr_n;
    logic                hdr_bad;
    logic [HDR_W-1:0]    word_cnt;
    logic                last_word;
    logic [ADDR_W-1:0]   wr_idx;
    logic                in_run;

    assign rx_fire   = rx_valid && rx_ready;
    assign hdr_n     = {hdr_hi, rx_data};
    assign hdr_bad   = (hdr_n == '0) || (hdr_n > MAX_WORDS);
    assign last_word = (word_cnt == HDR_W'(1));
    assign in_run    = (state == ST_RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_next = state;
        load_start = 1'b0;
        case (state)
            ST_IDLE, ST_RUN, ST_ERR: begin
                if (load_req) begin
                    load_start = 1'b1;
                    state_next = ST_HDR_HI;
                end
            end
            ST_HDR_HI:  if (rx_fire) state_next = ST_HDR_LO;
            ST_HDR_LO:  if (rx_fire) state_next = hdr_bad ? ST_ERR : ST_DATA_HI;
            ST_DATA_HI: if (rx_fire) state_next = ST_DATA_LO;
            ST_DATA_LO: if (rx_fire) state_next = last_word ? ST_FLUSH : ST_DATA_HI;
            ST_FLUSH:   state_next = ST_RUN;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            loaded     <= 1'b0;
            err        <= 1'b0;
            ovf_sticky <= 1'b0;
            hdr_hi     <= '0;
            data_hi    <= '0;
            word_cnt   <= '0;
            wr_idx     <= '0;
        end else begin
            // rx_ready is registered from the next state so it tracks the byte states exactly.
            rx_ready <= (state_next inside {ST_HDR_HI, ST_HDR_LO, ST_DATA_HI, ST_DATA_LO});
            imem_we  <= 1'b0;

            if (load_start) begin
                core_reset <= 1'b1;
                loaded     <= 1'b0;
                err        <= 1'b0;
                ovf_sticky <= 1'b0;
            end else if (in_run && overflow) begin
                ovf_sticky <= 1'b1;
            end

            if (state == ST_FLUSH) begin
                core_reset <= 1'b0;
                loaded     <= 1'b1;
            end

            if (rx_fire) begin
                case (state)
                    ST_HDR_HI:  hdr_hi <= rx_data;
                    ST_HDR_LO: begin
                        if (hdr_bad) begin
                            err <= 1'b1;
                        end else begin
                            word_cnt <= hdr_n;
                            wr_idx   <= '0;
                        end
                    end
                    ST_DATA_HI: data_hi <= rx_data;
                    ST_DATA_LO: begin
                        imem_we    <= 1'b1;
                        imem_wdata <= {data_hi, rx_data};
                        imem_addr  <= wr_idx;
                        wr_idx     <= wr_idx + ADDR_W'(1);
                        word_cnt   <= word_cnt - HDR_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    // A load request clears the counters even when it coincides with an overflow.
    sat_counter #(.W(OVF_CNT_W)) u_ovf_count (
        .clk   (clk),
        .reset (reset),
        .clr   (load_start),
        .en    (in_run && overflow),
        .count (ovf_count)
    );

    sat_counter #(.W(RUN_CNT_W)) u_run_cycles (
        .clk   (clk),
        .reset (reset),
        .clr   (load_start),
        .en    (in_run),
        .count (run_cycles)
    );

endmodule

// File: tb/tb_core_loader.sv
// Self-checking bench for core_loader: header vector table, randomized program
// loads with backpressure, overflow monitor and mid-load reset sequences.
module tb_core_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_req;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        core_reset;
    logic        overflow;
    logic        loaded;
    logic        err;
    logic        ovf_sticky;
    logic [7:0]  ovf_count;
    logic [15:0] run_cycles;

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] prog[$];
    logic [7:0]  obs_addr[$];
    logic [15:0] obs_data[$];

    typedef struct {
        logic [15:0] n;
        bit          exp_err;
        bit          exp_ready;
        bit          exp_core_reset;
    } hdr_vec_t;

    hdr_vec_t hv[6];

    core_loader #(.IMEM_DEPTH(256), .ADDR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_req   (load_req),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_reset (core_reset),
        .overflow   (overflow),
        .loaded     (loaded),
        .err        (err),
        .ovf_sticky (ovf_sticky),
        .ovf_count  (ovf_count),
        .run_cycles (run_cycles)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            obs_addr.push_back(imem_addr);
            obs_data.push_back(imem_wdata);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rx_ready"},   rx_ready,   0);
        check({tag, " imem_we"},    imem_we,    0);
        check({tag, " imem_addr"},  imem_addr,  0);
        check({tag, " imem_wdata"}, imem_wdata, 0);
        check({tag, " core_reset"}, core_reset, 1);
        check({tag, " loaded"},     loaded,     0);
        check({tag, " err"},        err,        0);
        check({tag, " ovf_sticky"}, ovf_sticky, 0);
        check({tag, " ovf_count"},  ovf_count,  0);
        check({tag, " run_cycles"}, run_cycles, 0);
    endtask

    // Drives one byte from a negedge and returns on the negedge after it was taken.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int waits = 0;
        if (gaps) begin
            int g = $urandom_range(0, 3);
            repeat (g) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && waits < 200) begin
            @(negedge clk);
            waits++;
        end
        if (!rx_ready) begin
            check("rx_ready timeout", rx_ready, 1);
        end else begin
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        check("load rx_ready",   rx_ready,   1);
        check("load core_reset", core_reset, 1);
        check("load loaded",     loaded,     0);
        check("load err",        err,        0);
        check("load ovf_sticky", ovf_sticky, 0);
        check("load ovf_count",  ovf_count,  0);
        check("load run_cycles", run_cycles, 0);
    endtask

    // Sends header and the words in prog; the reference model is simply
    // "word i lands at address i", with release two cycles after the last byte.
    task automatic load_body(input logic [15:0] n, input bit gaps, input bit exp_err);
        logic [15:0] w;
        obs_addr.delete();
        obs_data.delete();
        send_byte(n[15:8], gaps);
        send_byte(n[7:0], gaps);
        check("hdr err", err, 32'(exp_err));
        check("hdr core_reset", core_reset, 1);
        if (exp_err) begin
            check("hdr rx_ready", rx_ready, 0);
            return;
        end
        for (int i = 0; i < int'(n); i++) begin
            w = prog[i];
            send_byte(w[15:8], gaps);
            send_byte(w[7:0], gaps);
        end
        check("flush imem_we",    imem_we,    1);
        check("flush core_reset", core_reset, 1);
        @(negedge clk);
        check("release core_reset", core_reset, 0);
        check("release loaded",     loaded,     1);
        check("release imem_we",    imem_we,    0);
        check("release run_cycles", run_cycles, 0);
        check("write count", obs_addr.size(), 32'(n));
        for (int i = 0; i < obs_addr.size() && i < int'(n); i++) begin
            check("write addr", obs_addr[i], i % 256);
            check("write data", obs_data[i], prog[i]);
        end
    endtask

    task automatic fill_random(input int n);
        prog.delete();
        for (int i = 0; i < n; i++) prog.push_back(16'($urandom));
    endtask

    initial begin
        int ones;
        int run_exp;

        reset    = 1'b0;
        load_req = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        overflow = 1'b0;

        hv[0] = '{16'd0,      1'b1, 1'b0, 1'b1};
        hv[1] = '{16'd257,    1'b1, 1'b0, 1'b1};
        hv[2] = '{16'hFFFF,   1'b1, 1'b0, 1'b1};
        hv[3] = '{16'd1,      1'b0, 1'b1, 1'b1};
        hv[4] = '{16'd256,    1'b0, 1'b1, 1'b1};
        hv[5] = '{16'd7,      1'b0, 1'b1, 1'b1};

        // Reset state, and a valid byte without load_req must not be taken.
        repeat (3) @(negedge clk);
        check_reset_outputs("in reset");
        reset = 1'b1;
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        overflow = 1'b1;
        repeat (4) @(negedge clk);
        check_reset_outputs("idle");
        rx_valid = 1'b0;
        overflow = 1'b0;

        // Nominal load: 3 words, back-to-back bytes.
        prog.delete();
        prog.push_back(16'h1234);
        prog.push_back(16'hABCD);
        prog.push_back(16'h0001);
        pulse_load();
        load_body(16'd3, 1'b0, 1'b0);

        // Header table: bad counts go to ERR, good ones load random words with gaps.
        for (int v = 0; v < 6; v++) begin
            fill_random(int'(hv[v].n > 16'd256 ? 16'd0 : hv[v].n));
            pulse_load();
            if (hv[v].exp_err) begin
                load_body(hv[v].n, 1'b1, 1'b1);
                check("tbl rx_ready",   rx_ready,   32'(hv[v].exp_ready));
                check("tbl core_reset", core_reset, 32'(hv[v].exp_core_reset));
                repeat (3) @(negedge clk);
                check("tbl err holds", err, 1);
            end else begin
                send_byte(hv[v].n[15:8], 1'b1);
                send_byte(hv[v].n[7:0], 1'b1);
                check("tbl rx_ready",   rx_ready,   32'(hv[v].exp_ready));
                check("tbl core_reset", core_reset, 32'(hv[v].exp_core_reset));
                check("tbl err",        err,        32'(hv[v].exp_err));
                obs_addr.delete();
                obs_data.delete();
                for (int i = 0; i < int'(hv[v].n); i++) begin
                    send_byte(prog[i][15:8], 1'b1);
                    send_byte(prog[i][7:0], 1'b1);
                end
                @(negedge clk);
                check("tbl loaded",     loaded,          1);
                check("tbl writes",     obs_addr.size(), 32'(hv[v].n));
                for (int i = 0; i < obs_addr.size() && i < int'(hv[v].n); i++) begin
                    check("tbl write addr", obs_addr[i], i % 256);
                    check("tbl write data", obs_data[i], prog[i]);
                end
            end
        end

        // Backpressure: nominal program with random valid gaps.
        prog.delete();
        prog.push_back(16'h1234);
        prog.push_back(16'hABCD);
        prog.push_back(16'h0001);
        pulse_load();
        load_body(16'd3, 1'b1, 1'b0);

        // Random overflow pattern in RUN against a counting model.
        ones    = 0;
        run_exp = 0;
        for (int c = 0; c < 500; c++) begin
            overflow = ($urandom_range(0, 3) == 0);
            if (overflow) ones++;
            run_exp++;
            @(negedge clk);
        end
        overflow = 1'b0;
        check("rand ovf_count",  ovf_count,  (ones > 255) ? 255 : ones);
        check("rand ovf_sticky", ovf_sticky, (ones > 0) ? 1 : 0);
        check("rand run_cycles", run_cycles, run_exp);

        // load_req together with overflow: the clear wins.
        load_req = 1'b1;
        overflow = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
        overflow = 1'b0;
        check("clr ovf_count",  ovf_count,  0);
        check("clr ovf_sticky", ovf_sticky, 0);
        check("clr run_cycles", run_cycles, 0);
        check("clr core_reset", core_reset, 1);
        check("clr loaded",     loaded,     0);

        // Continue from HDR_HI: short load, then saturate both counters.
        fill_random(3);
        load_body(16'd3, 1'b0, 1'b0);
        overflow = 1'b1;
        repeat (300) @(negedge clk);
        overflow = 1'b0;
        check("sat ovf_count",  ovf_count,  255);
        check("sat ovf_sticky", ovf_sticky, 1);
        check("sat run_cycles 300", run_cycles, 300);
        repeat (65300) @(negedge clk);
        check("sat run_cycles", run_cycles, 16'hFFFF);
        check("sat ovf_count holds", ovf_count, 255);
        pulse_load();

        // Mid-load reset after the second word is accepted.
        fill_random(5);
        obs_addr.delete();
        obs_data.delete();
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        for (int i = 0; i < 2; i++) begin
            send_byte(prog[i][15:8], 1'b0);
            send_byte(prog[i][7:0], 1'b0);
        end
        #2 reset = 1'b0;
        #1;
        check_reset_outputs("midload reset");
        repeat (2) @(negedge clk);
        check("midload writes", obs_addr.size(), 2);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("after midload");
        fill_random(5);
        pulse_load();
        load_body(16'd5, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
